// File: rtl/sched_pkg.sv
// Shared types and constants for the instruction scheduler: FSM states,
// instruction field layout and the HALT opcode.
package sched_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPC_W    = 4;
   localparam int unsigned REG_W    = 4;
   localparam int unsigned OPC_LSB  = 12;
   localparam int unsigned DST_LSB  = 8;
   localparam int unsigned SRCA_LSB = 4;
   localparam int unsigned SRCB_LSB = 0;
   localparam int unsigned CNT_W    = 8;

   localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HALTED,
      ST_ERROR
   } state_e;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] dst;
      logic [REG_W-1:0] src_a;
      logic [REG_W-1:0] src_b;
   } instr_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return instr[OPC_LSB +: OPC_W] == OPC_HALT;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: power-of-two circular buffer with occupancy count,
// registered full flag and a synchronous flush.
module instr_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             wr_ok, rd_ok;

   assign wr_ok = wr_en && !full_q && !flush;
   assign rd_ok = rd_en && (count_q != '0) && !flush;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      full_d   = full_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         full_d   = 1'b0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
         full_d  = (count_d == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = full_q;

endmodule

// File: rtl/instr_scheduler.sv
// Issues queued instructions to a datapath one at a time, waiting for a
// completion strobe, with HALT, timeout error and synchronous clear.
module instr_scheduler
   import sched_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   input  logic [INSTR_W-1:0]      load_data,
   output logic                    load_ready,
   input  logic                    start,
   input  logic                    clear,
   input  logic                    instr_done,
   output logic [INSTR_W-1:0]      instr_out,
   output logic                    instr_valid,
   output logic                    busy,
   output logic                    halted,
   output logic                    error,
   output logic [CNT_W-1:0]        issue_cnt,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [INSTR_W-1:0]  instr_out_q, instr_out_d;
   logic                instr_valid_q, instr_valid_d;
   logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
   logic                busy_q, busy_d;
   logic                halted_q, halted_d;
   logic                error_q, error_d;

   logic                fifo_full;
   logic [INSTR_W-1:0]  fifo_rd_data;
   logic [CW-1:0]       fifo_cnt;
   logic                push_c, pop_c;
   logic                fifo_nonempty;
   logic                issue_now;
   instr_t              head;

   assign push_c        = load_valid && !fifo_full && !clear;
   assign fifo_nonempty = (fifo_cnt != '0);
   assign head          = instr_t'(fifo_rd_data);

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (clear),
      .wr_en   (push_c),
      .wr_data (load_data),
      .rd_en   (pop_c),
      .rd_data (fifo_rd_data),
      .count   (fifo_cnt),
      .full    (fifo_full)
   );

   // Next state, timer and queue pop; clear overrides everything.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pop_c   = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && fifo_nonempty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               pop_c   = 1'b1;
               timer_d = '0;
               state_d = (head.opcode == OPC_HALT) ? ST_HALTED : ST_WAIT;
            end
            ST_WAIT: begin
               if (instr_done) begin
                  state_d = fifo_nonempty ? ST_ISSUE : ST_IDLE;
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  state_d = ST_ERROR;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            ST_HALTED: state_d = ST_HALTED;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are computed from the next state so the issue pulse lands in
   // the ISSUE cycle itself while remaining a flop output.
   always_comb begin
      issue_now     = (state_d == ST_ISSUE) && !is_halt(fifo_rd_data);
      instr_valid_d = issue_now;
      instr_out_d   = issue_now ? fifo_rd_data : instr_out_q;
      issue_cnt_d   = issue_cnt_q + CNT_W'(issue_now);
      busy_d        = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      halted_d      = (state_d == ST_HALTED);
      error_d       = (state_d == ST_ERROR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         instr_out_q   <= '0;
         instr_valid_q <= 1'b0;
         issue_cnt_q   <= '0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         instr_out_q   <= instr_out_d;
         instr_valid_q <= instr_valid_d;
         issue_cnt_q   <= issue_cnt_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
         error_q       <= error_d;
      end
   end

   assign load_ready  = !fifo_full;
   assign instr_out   = instr_out_q;
   assign instr_valid = instr_valid_q;
   assign issue_cnt   = issue_cnt_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign error       = error_q;
   assign fifo_count  = fifo_cnt;

endmodule

// File: tb/tb_instr_scheduler.sv
// Scoreboard bench for instr_scheduler: expected issues are queued as loads
// are driven and matched against every instr_valid pulse seen.
module tb_instr_scheduler;

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        start;
   logic        clear;
   logic        instr_done;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        busy;
   logic        halted;
   logic        error;
   logic [7:0]  issue_cnt;
   logic [3:0]  fifo_count;

   int unsigned vectors;
   int unsigned miscompares;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [7:0]  exp_cnt;

   instr_scheduler #(.DEPTH(8), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .start       (start),
      .clear       (clear),
      .instr_done  (instr_done),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .busy        (busy),
      .halted      (halted),
      .error       (error),
      .issue_cnt   (issue_cnt),
      .fifo_count  (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every issue pulse mid-cycle for later scoreboard matching.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) got_q.push_back(instr_out);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_valid = 1'b0; load_data = '0; start = 1'b0; clear = 1'b0; instr_done = 1'b0;
      exp_cnt = '0;
      tick(); tick();
      vectors++;
      if ({instr_valid, busy, halted, error, load_ready} !== 5'b00001) begin
         miscompares++;
         $display("FAIL reset_flags: got v/b/h/e/r=%b want 00001", {instr_valid, busy, halted, error, load_ready});
      end
      vectors++;
      if (instr_out !== 16'h0000 || issue_cnt !== 8'd0 || fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_values: got out=%h cnt=%0d fifo=%0d want 0/0/0", instr_out, issue_cnt, fifo_count);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [15:0] g, e;
      do_load(16'h3F8A); exp_q.push_back(16'h3F8A); exp_cnt++;
      do_load(16'hA0A0); exp_q.push_back(16'hA0A0); exp_cnt++;
      pulse_start();
      vectors++;
      if (instr_valid !== 1'b1 || instr_out !== 16'h3F8A || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_latency: got v=%b out=%h busy=%b want 1/3f8a/1", instr_valid, instr_out, busy);
      end
      tick(); tick();
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      vectors++;
      if (instr_valid !== 1'b1 || instr_out !== 16'hA0A0) begin
         miscompares++;
         $display("FAIL basic_done_latency: got v=%b out=%h want 1/a0a0", instr_valid, instr_out);
      end
      tick(); tick();
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      vectors++;
      if (busy !== 1'b0 || halted !== 1'b0 || error !== 1'b0 || fifo_count !== 4'd0 || issue_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL basic_end: got busy=%b h=%b e=%b fifo=%0d cnt=%0d want 0/0/0/0/%0d",
                  busy, halted, error, fifo_count, issue_cnt, exp_cnt);
      end
      vectors++;
      if (instr_valid !== 1'b0 || instr_out !== 16'hA0A0) begin
         miscompares++;
         $display("FAIL basic_hold: got v=%b out=%h want 0/a0a0", instr_valid, instr_out);
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL basic_issue: got %h want %h", g, e); end
      end
      vectors++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL basic_issue_count: got leftover %0d want leftover %0d", got_q.size(), exp_q.size());
         got_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_halt();
      logic [15:0] g, e;
      do_load(16'h1234); exp_q.push_back(16'h1234); exp_cnt++;
      do_load(16'hF000);
      do_load(16'h5678);
      pulse_start();
      tick();
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      vectors++;
      if (instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_no_issue: got v=%b want 0", instr_valid);
      end
      tick();
      vectors++;
      if (halted !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd1 || issue_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL halt_state: got h=%b busy=%b fifo=%0d cnt=%0d want 1/0/1/%0d", halted, busy, fifo_count, issue_cnt, exp_cnt);
      end
      pulse_start(); tick();
      vectors++;
      if (halted !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd1) begin
         miscompares++;
         $display("FAIL halt_start_ignored: got h=%b busy=%b fifo=%0d want 1/0/1", halted, busy, fifo_count);
      end
      clear = 1'b1; tick(); clear = 1'b0;
      vectors++;
      if (halted !== 1'b0 || fifo_count !== 4'd0 || issue_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL halt_clear: got h=%b fifo=%0d cnt=%0d want 0/0/%0d", halted, fifo_count, issue_cnt, exp_cnt);
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL halt_issue: got %h want %h", g, e); end
      end
      vectors++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL halt_issue_count: got leftover %0d want leftover %0d", got_q.size(), exp_q.size());
         got_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_timeout();
      do_load(16'h0001); exp_q.push_back(16'h0001); exp_cnt++;
      pulse_start();
      tick();
      for (int i = 0; i < 14; i++) tick();
      vectors++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_early: got err=%b busy=%b in wait cycle 15 want 0/1", error, busy);
      end
      tick();
      vectors++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_error: got err=%b busy=%b want 1/0", error, busy);
      end
      instr_done = 1'b1; pulse_start(); instr_done = 1'b0;
      vectors++;
      if (error !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky: got err=%b want 1", error);
      end
      clear = 1'b1; tick(); clear = 1'b0;
      vectors++;
      if (error !== 1'b0 || issue_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL timeout_clear: got err=%b cnt=%0d want 0/%0d", error, issue_cnt, exp_cnt);
      end
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         vectors++;
         if (got_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL timeout_issue: got %h want %h", got_q[0], exp_q[0]);
         end
      end
      vectors++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         miscompares++;
         $display("FAIL timeout_issue_count: got %0d pulses want 1", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_full();
      for (int i = 0; i < 9; i++) begin
         load_valid = 1'b1;
         load_data  = 16'h0100 + 16'(i);
         vectors++;
         if (load_ready !== (i < 8 ? 1'b1 : 1'b0)) begin
            miscompares++;
            $display("FAIL full_ready_%0d: got %b want %b", i, load_ready, (i < 8 ? 1'b1 : 1'b0));
         end
         tick();
      end
      load_valid = 1'b0;
      vectors++;
      if (fifo_count !== 4'd8 || load_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_count: got fifo=%0d ready=%b want 8/0", fifo_count, load_ready);
      end
      clear = 1'b1; tick();
      load_valid = 1'b1; load_data = 16'h4444; tick();
      clear = 1'b0; load_valid = 1'b0;
      vectors++;
      if (fifo_count !== 4'd0 || load_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_discards_load: got fifo=%0d ready=%b want 0/1", fifo_count, load_ready);
      end
   endtask

   task automatic test_push_pop();
      logic [15:0] g, e;
      for (int i = 0; i < 4; i++) begin
         do_load(16'h2100 + 16'(i)); exp_q.push_back(16'h2100 + 16'(i)); exp_cnt++;
      end
      start = 1'b1; tick(); start = 1'b0;
      load_valid = 1'b1; load_data = 16'h2222; exp_q.push_back(16'h2222); exp_cnt++;
      tick();
      load_valid = 1'b0;
      vectors++;
      if (fifo_count !== 4'd4) begin
         miscompares++;
         $display("FAIL push_pop_count: got fifo=%0d want 4", fifo_count);
      end
      for (int i = 0; i < 5; i++) begin
         instr_done = 1'b1; tick(); instr_done = 1'b0; tick();
      end
      vectors++;
      if (busy !== 1'b0 || fifo_count !== 4'd0 || issue_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL push_pop_end: got busy=%b fifo=%0d cnt=%0d want 0/0/%0d", busy, fifo_count, issue_cnt, exp_cnt);
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL push_pop_issue: got %h want %h", g, e); end
      end
      vectors++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL push_pop_issue_count: got leftover %0d want leftover %0d", got_q.size(), exp_q.size());
         got_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] g, e;
      do_load(16'h7001); exp_q.push_back(16'h7001);
      do_load(16'h7002);
      do_load(16'h7003);
      do_load(16'h7004);
      pulse_start();
      tick();
      vectors++;
      if (busy !== 1'b1 || fifo_count !== 4'd3) begin
         miscompares++;
         $display("FAIL reset_mid_setup: got busy=%b fifo=%0d want 1/3", busy, fifo_count);
      end
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      vectors++;
      if ({instr_valid, busy, halted, error, load_ready} !== 5'b00001 ||
          instr_out !== 16'h0000 || issue_cnt !== 8'd0 || fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_mid_values: got v/b/h/e/r=%b out=%h cnt=%0d fifo=%0d want 00001/0000/0/0",
                  {instr_valid, busy, halted, error, load_ready}, instr_out, issue_cnt, fifo_count);
      end
      tick();
      rst_n = 1'b1;
      instr_done = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      instr_done = 1'b0;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL reset_mid_issue: got %h want %h", g, e); end
      end
      vectors++;
      if (got_q.size() != 0 || exp_q.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_no_pulse: got extra %0d pulses busy=%b want 0/0", got_q.size(), busy);
         got_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] g, e, d, last;
      bit drained;
      last = 16'h0000;
      for (int i = 0; i < 6; i++) begin
         d = 16'h3000 + 16'(i);
         do_load(d); exp_q.push_back(d); exp_cnt++; last = d;
      end
      instr_done = 1'b1;
      for (int c = 0; c < 500; c++) begin
         d = 16'($urandom);
         if (d[15:12] == 4'hF) d[15:12] = 4'h1;
         start = 1'b1;
         load_valid = 1'b1;
         load_data  = d;
         if (load_ready === 1'b1) begin
            exp_q.push_back(d); exp_cnt++; last = d;
         end
         tick();
      end
      load_valid = 1'b0;
      drained = 1'b0;
      for (int c = 0; c < 64 && !drained; c++) begin
         tick();
         if (fifo_count === 4'd0 && busy === 1'b0) drained = 1'b1;
      end
      start = 1'b0;
      instr_done = 1'b0;
      tick();
      vectors++;
      if (!drained) begin
         miscompares++;
         $display("FAIL b2b_drain: got fifo=%0d busy=%b after budget want 0/0", fifo_count, busy);
      end
      vectors++;
      if (issue_cnt !== exp_cnt || instr_out !== last) begin
         miscompares++;
         $display("FAIL b2b_counts: got cnt=%0d out=%h want %0d/%h", issue_cnt, instr_out, exp_cnt, last);
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL b2b_issue: got %h want %h", g, e); end
      end
      vectors++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_issue_count: got leftover %0d want leftover %0d", got_q.size(), exp_q.size());
         got_q.delete(); exp_q.delete();
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_halt();
      test_timeout();
      test_full();
      test_push_pop();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
